// File: rtl/sum_chain_pkg.sv
// Shared definitions for the chained-add sequencer: FSM encoding, default widths
// and requester-id helpers.
package sum_chain_pkg;

    localparam int DW_DEFAULT = 4;
    localparam int OW_DEFAULT = 5;
    localparam int ID_W       = 1;

    typedef logic [2:0]      state_t;
    typedef logic [ID_W-1:0] req_id_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADD_AB = 3'd1;
    localparam logic [2:0] ST_ADD_C  = 3'd2;
    localparam logic [2:0] ST_ADD_D  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Only two requesters exist, so the one-hot grant collapses to its upper bit.
    function automatic req_id_t onehot_to_id(input logic [1:0] onehot);
        return onehot[1];
    endfunction

endpackage

// File: rtl/sum_chain_sequencer_if.sv
// Request/result bus between the two requesting engines and the sequencer.
interface sum_chain_sequencer_if
    import sum_chain_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int OW = OW_DEFAULT
) ();

    logic [1:0]      req;
    logic [4*DW-1:0] opnd0;
    logic [4*DW-1:0] opnd1;
    logic [1:0]      sel;
    logic [1:0]      grant;
    logic            busy;
    logic            done;
    logic            done_id;
    logic [OW-1:0]   data_out1;
    logic [OW-1:0]   data_out2;

    modport master (
        output req, opnd0, opnd1, sel,
        input  grant, busy, done, done_id, data_out1, data_out2
    );

    modport slave (
        input  req, opnd0, opnd1, sel,
        output grant, busy, done, done_id, data_out1, data_out2
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = rr_last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/sum_chain_sequencer.sv
// Multi-cycle chained-add controller sharing one OW-bit adder between two requesters.
// Define SUM_CHAIN_SAT_EN for saturating adds; default build wraps mod 2^OW.
module sum_chain_sequencer
    import sum_chain_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int OW = OW_DEFAULT
) (
    input logic                  clk,
    input logic                  rst,
    sum_chain_sequencer_if.slave seq_if
);

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    req_id_t         done_id_q, done_id_d;
    logic            rr_last_q, rr_last_d;
    logic            sel_q, sel_d;
    logic [OW-1:0]   out1_q, out1_d;
    logic [OW-1:0]   out2_q, out2_d;

    logic [DW-1:0]   a_q, b_q, c_q, d_q;
    logic [1:0]      arb_grant;
    req_id_t         winner;
    req_id_t         owner;
    logic            latch_en;
    logic [4*DW-1:0] win_opnd;
    logic [OW-1:0]   add_x, add_y, add_sum;

    function automatic logic [OW-1:0] chain_add(input logic [OW-1:0] x, input logic [OW-1:0] y);
        logic [OW:0] full;
        full = {1'b0, x} + {1'b0, y};
`ifdef SUM_CHAIN_SAT_EN
        return full[OW] ? {OW{1'b1}} : full[OW-1:0];
`else
        return full[OW-1:0];
`endif
    endfunction

    rr_arbiter2 u_arb (
        .req_i     (seq_if.req),
        .rr_last_i (rr_last_q),
        .grant_o   (arb_grant)
    );

    assign winner   = onehot_to_id(arb_grant);
    assign owner    = onehot_to_id(grant_q);
    assign latch_en = (state_q == ST_IDLE) && (|seq_if.req);
    assign win_opnd = winner ? seq_if.opnd1 : seq_if.opnd0;

    // Operand latch: captured once at grant, later req/operand changes are ignored.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            {d_q, c_q, b_q, a_q} <= win_opnd;
        end
    end

    always_comb begin
        add_x = '0;
        add_y = '0;
        case (state_q)
            ST_ADD_AB: begin add_x = OW'(a_q);  add_y = OW'(b_q); end
            ST_ADD_C:  begin add_x = out1_q;    add_y = OW'(c_q); end
            ST_ADD_D:  begin add_x = out2_q;    add_y = OW'(d_q); end
            default:   begin add_x = '0;        add_y = '0;       end
        endcase
    end

    assign add_sum = chain_add(add_x, add_y);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        rr_last_d = rr_last_q;
        sel_d     = sel_q;
        out1_d    = out1_q;
        out2_d    = out2_q;
        case (state_q)
            ST_IDLE: begin
                if (latch_en) begin
                    grant_d = arb_grant;
                    busy_d  = 1'b1;
                    sel_d   = seq_if.sel[winner];
                    state_d = ST_ADD_AB;
                end
            end
            ST_ADD_AB: begin
                out1_d  = add_sum;
                state_d = ST_ADD_C;
            end
            ST_ADD_C: begin
                out2_d = add_sum;
                if (!sel_q) begin
                    state_d = ST_ADD_D;
                end else begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    done_id_d = owner;
                end
            end
            ST_ADD_D: begin
                out1_d    = add_sum;
                state_d   = ST_DONE;
                done_d    = 1'b1;
                done_id_d = owner;
            end
            ST_DONE: begin
                grant_d   = 2'b00;
                busy_d    = 1'b0;
                rr_last_d = owner;
                state_d   = ST_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // rr_last resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            rr_last_q <= 1'b1;
            sel_q     <= 1'b0;
            out1_q    <= '0;
            out2_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            rr_last_q <= rr_last_d;
            sel_q     <= sel_d;
            out1_q    <= out1_d;
            out2_q    <= out2_d;
        end
    end

    assign seq_if.grant     = grant_q;
    assign seq_if.busy      = busy_q;
    assign seq_if.done      = done_q;
    assign seq_if.done_id   = done_id_q;
    assign seq_if.data_out1 = out1_q;
    assign seq_if.data_out2 = out2_q;

endmodule
